// File: rtl/if_stage_if.sv
// Shared IF/ID record type and the instruction-memory request/response bundle.
// The request channel uses valid/ready handshaking; the response channel is valid-only.
package if_stage_pkg;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instruction;
        logic            valid_if_id;
    } if_id_reg_t;
endpackage

interface if_stage_if;
    logic                          imem_req_valid;
    logic                          imem_req_ready;
    logic [if_stage_pkg::XLEN-1:0] imem_req_addr;
    logic                          imem_rsp_valid;
    logic [31:0]                   imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, one-outstanding fetch FSM, one-entry hold buffer, IF/ID register.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    if_stage_if.master      imem,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_bubble_cnt,
`endif
    output if_id_reg_t      if_id_out
);

    typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            hold_valid_q, hold_valid_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]     hold_instr_q, hold_instr_d;
    if_id_reg_t      slot_q, slot_d;
    logic            bubble;

    logic req_fire;
    logic rsp_take;
    logic slot_stall;

    assign imem.imem_req_valid = !reset && (state_q == REQ) && !hold_valid_q;
    assign imem.imem_req_addr  = pc_q;
    assign req_fire   = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_take   = (state_q == WAIT) && imem.imem_rsp_valid && !flush;
    // An invalid slot is free even under stall: decode is not holding anything.
    assign slot_stall = stall && slot_q.valid_if_id;
    assign if_id_out  = slot_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        hold_valid_d = hold_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        slot_d       = slot_q;
        bubble       = 1'b0;

        case (state_q)
            REQ: begin
                if (req_fire) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + XLEN'(4);
                    state_d    = flush ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rsp_valid) state_d = REQ;
                else if (flush)          state_d = DROP;
            end
            DROP: begin
                if (imem.imem_rsp_valid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase

        if (flush) pc_d = {redirect_pc[XLEN-1:2], 2'b00};

        if (flush) begin
            slot_d.valid_if_id = 1'b0;
            slot_d.instruction = NOP_INSTR;
            hold_valid_d       = 1'b0;
        end else if (slot_stall) begin
            if (rsp_take) begin
                hold_valid_d = 1'b1;
                hold_pc_d    = fetch_pc_q;
                hold_instr_d = imem.imem_rsp_data;
            end
        end else if (hold_valid_q) begin
            slot_d       = '{pc: hold_pc_q, instruction: hold_instr_q, valid_if_id: 1'b1};
            hold_valid_d = 1'b0;
        end else if (rsp_take) begin
            slot_d = '{pc: fetch_pc_q, instruction: imem.imem_rsp_data, valid_if_id: 1'b1};
        end else if (!stall) begin
            slot_d.valid_if_id = 1'b0;
            slot_d.instruction = NOP_INSTR;
            bubble             = 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    always_comb begin
        perf_fetch_d  = perf_fetch_q + (rsp_take ? 32'd1 : 32'd0);
        perf_bubble_d = perf_bubble_q + (bubble ? 32'd1 : 32'd0);
    end

    assign perf_fetch_cnt  = perf_fetch_q;
    assign perf_bubble_cnt = perf_bubble_q;
`else
    logic unused_bubble;
    assign unused_bubble = bubble;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= '0;
            hold_valid_q <= 1'b0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
            slot_q       <= '{pc: '0, instruction: NOP_INSTR, valid_if_id: 1'b0};
`ifdef IF_PERF_CNT_EN
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            slot_q       <= slot_d;
`ifdef IF_PERF_CNT_EN
            perf_fetch_q  <= perf_fetch_d;
            perf_bubble_q <= perf_bubble_d;
`endif
        end
    end

    // A response with no request outstanding is a memory-side protocol error.
    rsp_in_req_a: assert property (@(posedge clk) disable iff (reset)
        !(imem.imem_rsp_valid && state_q == REQ));

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic against a transaction-level model.
// Counter checks are included when IF_PERF_CNT_EN is defined.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    if_id_reg_t  if_id_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    if_stage_if bus ();

    if_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem        (bus.master),
`ifdef IF_PERF_CNT_EN
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt),
`endif
        .if_id_out   (if_id_out)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;

    // Reference model: program-order fetch stream with at most one word in flight.
    bit          m_out, m_killed, m_accept, m_slot_v;
    logic [31:0] m_pc, m_fetch, m_slot_pc, m_slot_instr;
    logic [63:0] m_pend[$];
    int unsigned m_fetches, m_bubbles;

    int          mem_cnt;
    int          mem_delay;
    logic [31:0] mem_addr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0010_0093 : ((a * 32'h9E37_79B1) ^ 32'h13);
    endfunction

    function automatic bit m_req_valid();
        return !m_out && (m_pend.size() == 0);
    endfunction

    task automatic model_reset();
        m_out = 0; m_killed = 0; m_accept = 0; m_slot_v = 0;
        m_pc = 32'h0; m_fetch = 32'h0; m_slot_pc = 32'h0; m_slot_instr = NOP;
        m_pend.delete();
        m_fetches = 0; m_bubbles = 0;
    endtask

    task automatic model_step();
        bit          good;
        logic [63:0] w;
        m_accept = m_req_valid() && bus.imem_req_ready;
        good = bus.imem_rsp_valid && m_out && !m_killed && !flush;
        w = {m_fetch, bus.imem_rsp_data};
        if (good) m_fetches++;
        if (flush) begin
            m_slot_v = 0; m_slot_instr = NOP; m_pend.delete();
        end else if (stall && m_slot_v) begin
            if (good) m_pend.push_back(w);
        end else if (m_pend.size() != 0) begin
            w = m_pend.pop_front();
            m_slot_v = 1; m_slot_pc = w[63:32]; m_slot_instr = w[31:0];
        end else if (good) begin
            m_slot_v = 1; m_slot_pc = w[63:32]; m_slot_instr = w[31:0];
        end else if (!stall) begin
            m_slot_v = 0; m_slot_instr = NOP; m_bubbles++;
        end
        if (bus.imem_rsp_valid) m_out = 0;
        if (m_accept) begin
            m_out = 1; m_killed = 0; m_fetch = m_pc; m_pc = m_pc + 32'd4;
        end
        if (flush) begin
            if (m_out) m_killed = 1;
            m_pc = {redirect_pc[31:2], 2'b00};
        end
    endtask

    // Advance one clock: model consumes this cycle's inputs, memory schedules its response.
    task automatic tick();
        if (reset) model_reset(); else model_step();
        @(posedge clk);
        #1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
        if (reset) begin
            mem_cnt = 0;
        end else begin
            if (m_accept) begin mem_cnt = mem_delay; mem_addr = m_fetch; end
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem(mem_addr);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %0b want 0", bus.imem_req_valid); else passes++;
        checks++; if (if_id_out !== '{pc: 32'h0, instruction: NOP, valid_if_id: 1'b0})
            $display("FAIL reset_if_id: got %h want %h", if_id_out, {32'h0, NOP, 1'b0}); else passes++;
`ifdef IF_PERF_CNT_EN
        checks++; if (perf_fetch_cnt !== 32'h0) $display("FAIL reset_perf_fetch: got %0d want 0", perf_fetch_cnt); else passes++;
        checks++; if (perf_bubble_cnt !== 32'h0) $display("FAIL reset_perf_bubble: got %0d want 0", perf_bubble_cnt); else passes++;
`endif
        reset = 1'b0;
        #1;
    endtask

    task automatic test_basic_fetch();
        bus.imem_req_ready = 1'b1; mem_delay = 1;
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0)
            $display("FAIL basic_first_req: got v=%0b a=%h want v=1 a=0", bus.imem_req_valid, bus.imem_req_addr); else passes++;
        tick();
        checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL basic_wait_req: got %0b want 0", bus.imem_req_valid); else passes++;
        tick();
        checks++; if (if_id_out !== '{pc: 32'h0, instruction: 32'h0010_0093, valid_if_id: 1'b1})
            $display("FAIL basic_slot: got %h want %h", if_id_out, {32'h0, 32'h0010_0093, 1'b1}); else passes++;
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h4)
            $display("FAIL basic_next_req: got v=%0b a=%h want v=1 a=4", bus.imem_req_valid, bus.imem_req_addr); else passes++;
    endtask

    task automatic test_stall_hold();
        tick(); tick();
        checks++; if (if_id_out.valid_if_id !== 1'b1 || if_id_out.pc !== 32'h4)
            $display("FAIL stall_pre_slot: got v=%0b pc=%h want v=1 pc=4", if_id_out.valid_if_id, if_id_out.pc); else passes++;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) stall = 1'b0;
            checks++; if (if_id_out.valid_if_id !== 1'b1 || if_id_out.pc !== 32'h4)
                $display("FAIL stall_hold_slot[%0d]: got v=%0b pc=%h want v=1 pc=4", i, if_id_out.valid_if_id, if_id_out.pc); else passes++;
            checks++; if (bus.imem_req_valid !== 1'b0)
                $display("FAIL stall_no_req[%0d]: got %0b want 0", i, bus.imem_req_valid); else passes++;
        end
        tick();
        checks++; if (if_id_out !== '{pc: 32'h8, instruction: mem(32'h8), valid_if_id: 1'b1})
            $display("FAIL stall_drain_slot: got %h want %h", if_id_out, {32'h8, mem(32'h8), 1'b1}); else passes++;
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hC)
            $display("FAIL stall_next_req: got v=%0b a=%h want v=1 a=c", bus.imem_req_valid, bus.imem_req_addr); else passes++;
    endtask

    task automatic test_flush_wait();
        mem_delay = 4;
        tick();
        mem_delay = 1;
        flush = 1'b1; redirect_pc = 32'h100;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (if_id_out.valid_if_id !== 1'b0 || bus.imem_req_valid !== 1'b0)
                $display("FAIL flushw_drop[%0d]: got slot_v=%0b req_v=%0b want 0 0", i, if_id_out.valid_if_id, bus.imem_req_valid); else passes++;
            tick();
        end
        checks++; if (if_id_out.valid_if_id !== 1'b0) $display("FAIL flushw_slot: got %0b want 0", if_id_out.valid_if_id); else passes++;
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100)
            $display("FAIL flushw_req: got v=%0b a=%h want v=1 a=100", bus.imem_req_valid, bus.imem_req_addr); else passes++;
    endtask

    task automatic test_flush_stall();
        tick(); tick();
        checks++; if (if_id_out.valid_if_id !== 1'b1 || if_id_out.pc !== 32'h100)
            $display("FAIL fs_pre_slot: got v=%0b pc=%h want v=1 pc=100", if_id_out.valid_if_id, if_id_out.pc); else passes++;
        flush = 1'b1; stall = 1'b1; redirect_pc = 32'h100;
        tick();
        flush = 1'b0; stall = 1'b0;
        checks++; if (if_id_out.valid_if_id !== 1'b0 || if_id_out.instruction !== NOP)
            $display("FAIL fs_slot: got v=%0b i=%h want v=0 i=%h", if_id_out.valid_if_id, if_id_out.instruction, NOP); else passes++;
        tick();
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100)
            $display("FAIL fs_req: got v=%0b a=%h want v=1 a=100", bus.imem_req_valid, bus.imem_req_addr); else passes++;
    endtask

    task automatic test_wrap();
        bus.imem_req_ready = 1'b0; flush = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        flush = 1'b0; bus.imem_req_ready = 1'b1;
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_req: got v=%0b a=%h want v=1 a=fffffffc", bus.imem_req_valid, bus.imem_req_addr); else passes++;
        tick(); tick();
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0)
            $display("FAIL wrap_next_req: got v=%0b a=%h want v=1 a=0", bus.imem_req_valid, bus.imem_req_addr); else passes++;
        checks++; if (if_id_out !== '{pc: 32'hFFFF_FFFC, instruction: mem(32'hFFFF_FFFC), valid_if_id: 1'b1})
            $display("FAIL wrap_slot: got %h want %h", if_id_out, {32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1'b1}); else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            bus.imem_req_ready = ($urandom_range(0, 9) < 7);
            mem_delay = $urandom_range(1, 3);
            tick();
            checks++; if (bus.imem_req_valid !== m_req_valid())
                $display("FAIL rnd_req_valid @%0d: got %0b want %0b", i, bus.imem_req_valid, m_req_valid()); else passes++;
            if (m_req_valid()) begin
                checks++; if (bus.imem_req_addr !== m_pc)
                    $display("FAIL rnd_req_addr @%0d: got %h want %h", i, bus.imem_req_addr, m_pc); else passes++;
            end
            checks++; if (if_id_out.valid_if_id !== m_slot_v)
                $display("FAIL rnd_slot_valid @%0d: got %0b want %0b", i, if_id_out.valid_if_id, m_slot_v); else passes++;
            if (m_slot_v) begin
                checks++; if (if_id_out.pc !== m_slot_pc || if_id_out.instruction !== m_slot_instr)
                    $display("FAIL rnd_slot_word @%0d: got %h/%h want %h/%h", i, if_id_out.pc, if_id_out.instruction, m_slot_pc, m_slot_instr); else passes++;
            end else begin
                checks++; if (if_id_out.instruction !== NOP)
                    $display("FAIL rnd_slot_nop @%0d: got %h want %h", i, if_id_out.instruction, NOP); else passes++;
            end
`ifdef IF_PERF_CNT_EN
            checks++; if (perf_fetch_cnt !== m_fetches || perf_bubble_cnt !== m_bubbles)
                $display("FAIL rnd_perf @%0d: got %0d/%0d want %0d/%0d", i, perf_fetch_cnt, perf_bubble_cnt, m_fetches, m_bubbles); else passes++;
`endif
        end
        stall = 1'b0; flush = 1'b0;
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        int cyc;
        test_reset();
        bus.imem_req_ready = 1'b1; mem_delay = 1; redirect_pc = 32'h200;
        cyc = 0;
        while (m_fetches < 10 && cyc < 300) begin
            stall = (cyc >= 6 && cyc < 10);
            flush = (cyc == 15);
            tick();
            cyc++;
        end
        stall = 1'b0; flush = 1'b0;
        checks++; if (cyc >= 300) $display("FAIL perf_budget: got %0d fetches want 10 within 300 cycles", m_fetches); else passes++;
        checks++; if (perf_fetch_cnt !== m_fetches) $display("FAIL perf_fetch: got %0d want %0d", perf_fetch_cnt, m_fetches); else passes++;
        checks++; if (perf_bubble_cnt !== m_bubbles) $display("FAIL perf_bubble: got %0d want %0d", perf_bubble_cnt, m_bubbles); else passes++;
    endtask
`endif

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
        mem_delay = 1; mem_cnt = 0; mem_addr = 32'h0;
        model_reset();
        test_reset();
        test_basic_fetch();
        test_stall_hold();
        test_flush_wait();
        test_flush_stall();
        test_wrap();
        test_random();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage and owner of the IF/ID pipeline register; produces the `if_id_reg_t` that the decode stage consumes.
- Holds the PC and issues fetch requests to instruction memory over a valid/ready request channel with a valid-only response channel.
- Applies stall (hold) and flush/redirect (kill and re-steer) from the hazard and branch logic.
- Allows one outstanding request and has a one-entry hold buffer for a response that arrives while decode is stalled.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013: value placed in `instruction` whenever the IF/ID slot is invalid (addi x0,x0,0).

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  decode cannot accept; hold if_id_out
- flush  input  1  redirect request (taken branch/jump from EX)
- redirect_pc  input  XLEN  new fetch address, sampled when flush=1
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  XLEN  fetch address, word aligned
- imem_rsp_valid  input  1  response data valid; exactly one per accepted request, at least 1 cycle after acceptance
- imem_rsp_data  input  32  fetched instruction
- if_id_out  output  if_id_reg_t  {pc, instruction, valid_if_id}, registered

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - state = REQ; pc_q = RESET_PC; hold buffer empty.
  - if_id_out = {pc 0, instruction NOP_INSTR, valid_if_id 0}.
  - imem_req_valid = 0 during any cycle with reset=1.
- State REQ:
  - imem_req_valid = 1 (unless hold buffer full); imem_req_addr = pc_q.
  - On req_valid && req_ready: fetch_pc_q <= pc_q, pc_q <= pc_q + 4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), go WAIT.
- State WAIT:
  - imem_req_valid = 0.
  - On rsp_valid, the word {fetch_pc_q, rsp_data} goes to the IF/ID slot if the slot is free (valid_if_id = 0, or stall = 0); otherwise it goes to the hold buffer. Then go REQ.
- State DROP (request killed by flush is still outstanding):
  - imem_req_valid = 0.
  - On rsp_valid, discard the data and go REQ.
- IF/ID slot update priority, highest first:
  1. flush: valid_if_id <= 0, instruction <= NOP_INSTR, hold buffer cleared.
  2. stall: slot unchanged.
  3. Hold buffer full: slot <= buffer entry, buffer cleared.
  4. Response accepted this cycle: slot <= response.
  5. Otherwise valid_if_id <= 0 (bubble).
- Hold buffer full:
  - No new request is issued (req_valid = 0) until the buffer drains.
  - At most one word is ever in flight plus one buffered, so there is no overflow.
- Flush (wins over stall and over a same-cycle response):
  - pc_q <= {redirect_pc[XLEN-1:2], 2'b00}.
  - REQ without handshake → REQ; the new address is presented next cycle. Withdrawing an un-accepted request is legal only on flush.
  - REQ with handshake in the same cycle → DROP.
  - WAIT without rsp_valid → DROP.
  - WAIT with rsp_valid → REQ; the response is discarded.
  - DROP: stays DROP (pc_q updated) unless rsp_valid, then REQ.
- Latency and throughput:
  - With req_ready = 1 and response 1 cycle after acceptance: request at cycle N, response at N+1, if_id_out.valid_if_id = 1 at N+2.
  - Peak throughput is 1 instruction per 2 cycles.
- Response while in REQ: protocol violation; ignored. The simulation assertion fires.
- if_id_out.pc of a valid slot always equals the address that produced the instruction.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_fetch_cnt (32): increments once per response written to the slot or the hold buffer, i.e. accepted and not dropped.
  - perf_bubble_cnt (32): increments each cycle the slot updates to invalid, i.e. priority case 5, excluding flush.
  - Both reset to 0 and wrap at 2^32.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, req_ready = 1, memory returns 32'h0010_0093 one cycle after acceptance → req_addr 0x0 at cycle 1, if_id_out {pc 0x0, instr 0x00100093, valid 1} at cycle 3, next req_addr 0x4.
- stall = 1 for 5 cycles while the slot holds pc 0x4 and a response for pc 0x8 arrives:
  - Slot stays at pc 0x4.
  - pc 0x8 is held in the buffer and no request is issued.
  - On stall = 0, the slot becomes pc 0x8, then the request for 0xC is issued.
- flush with redirect_pc = 0x100 in WAIT; response arrives 3 cycles later → response discarded, valid_if_id = 0, next req_addr 0x100, no valid slot with the old pc.
- flush and stall asserted together with a valid slot → next cycle valid_if_id = 0, instruction = NOP_INSTR, pc_q = 0x100.
- redirect_pc = 32'hFFFF_FFFE → req_addr 0xFFFF_FFFC; after acceptance, next req_addr is 0x0000_0000.
- With IF_PERF_CNT_EN, 10 fetches with one flush and 4 stalled cycles → perf_fetch_cnt equals accepted-and-not-dropped responses; perf_bubble_cnt equals non-flush cycles in which the slot updated to invalid. Compare both against the scoreboard.
